// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Fetch-stage sequencer for a 5-stage RISC-V pipeline whose instruction
// memory is a multi-cycle request/grant/response port. It owns the program
// counter and keeps at most one fetch outstanding. It applies execute-stage
// redirects and decode-stage stalls, discards responses that belong to a
// squashed path, and drives the IF/ID pipeline register.
//
// Ports
//   clk          in   pipeline clock, all state updates on posedge
//   rst          in   asynchronous active-low reset
//   StallD       in   decode cannot accept; IF/ID must hold
//   PCSrcE       in   taken branch/jump from execute (one-cycle pulse)
//   PCTargetE    in   redirect target, valid with PCSrcE
//   imem_req     out  fetch request
//   imem_addr    out  fetch address (word aligned)
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   response valid (one per accepted request)
//   imem_rdata   in   instruction word
//   InstrD       out  IF/ID instruction
//   PCD          out  IF/ID PC
//   PCPlus4D     out  IF/ID PC+4
//   ValidD       out  IF/ID holds a real instruction
//   fsm_state    out  current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 HOLD)
//
// Handshake: a request transfers in the cycle where imem_req & imem_gnt are
// both high; imem_req/imem_addr stay stable until then, except when a
// redirect retargets the address. Exactly one imem_rvalid pulse answers each
// transferred request, no earlier than the cycle after the grant. The
// controller always accepts the response (no back-pressure on rvalid).
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;

    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_valid_q, skid_valid_d;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] skid_pc_plus4;
    logic [31:0] redirect_pc;
    logic        can_load;

    // Plain 32-bit adds: wrap from 0xFFFFFFFC to 0 is intended.
    assign pc_plus4      = pc_q + 32'd4;
    assign skid_pc_plus4 = skid_pc_q + 32'd4;
    assign redirect_pc   = {PCTargetE[31:2], 2'b00};

    // IF/ID may be overwritten when decode is not stalled, or when it holds
    // nothing worth keeping.
    assign can_load = !StallD || !valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;

        case (state_q)
            ST_IDLE: begin
                // A response arriving here belongs to a fetch abandoned by
                // reset and is ignored.
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (can_load) begin
                        instr_d = imem_rdata;
                        pcd_d   = pc_q;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = ST_REQ;
                    end else begin
                        // Decode is stalled on a valid instruction: park the
                        // response and stop fetching until it drains.
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        skid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!StallD) begin
                    instr_d      = skid_instr_q;
                    pcd_d        = skid_pc_q;
                    pc4_d        = skid_pc_plus4;
                    valid_d      = skid_valid_q;
                    skid_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect overrides everything above, including a stalled decode.
        if (PCSrcE) begin
            pc_d         = redirect_pc;
            instr_d      = 32'h0;
            pcd_d        = 32'h0;
            pc4_d        = 32'h0;
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            case (state_q)
                ST_REQ: begin
                    // A grant in this cycle was for the old address; its
                    // response must be thrown away.
                    if (imem_gnt) begin
                        state_d = ST_WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                    kill_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            instr_q      <= 32'h0;
            pcd_q        <= 32'h0;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pc4_q;
    assign ValidD    = valid_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Directed bench for fetch_controller. A memory model grants every request
// and answers with data = addr | 0x13 after a configurable latency. Each
// instruction expected to reach IF/ID is pushed into exp_q as the stimulus
// is issued; a monitor pops and compares whenever IF/ID presents a new valid
// instruction. Point checks cover reset values, request/address timing,
// squashing on redirect, wrap-around and reset mid-transaction.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        StallD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [1:0]  fsm_state;

    logic        rv_auto;
    logic [31:0] rd_auto;
    logic        stray_rv;
    int          lat;

    int checks;
    int errors;

    logic [95:0] exp_q[$];

    assign imem_rvalid = rv_auto | stray_rv;
    assign imem_rdata  = stray_rv ? 32'hBAD00013 : rd_auto;

    fetch_controller #(.RESET_PC(32'h00000000)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallD     (StallD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model ----------------
    // Handshake sampled mid-cycle; response driven 1 time unit after the edge.
    initial begin : mem_model
        logic        hs;
        logic [31:0] hs_addr;
        logic        pend;
        logic [31:0] pend_addr;
        int          cnt;
        hs = 1'b0; hs_addr = '0; pend = 1'b0; pend_addr = '0; cnt = 0;
        rv_auto = 1'b0; rd_auto = '0;
        forever begin
            @(negedge clk);
            hs      = (imem_req === 1'b1) && (imem_gnt === 1'b1);
            hs_addr = imem_addr;
            @(posedge clk);
            #1;
            rv_auto = 1'b0;
            if (rst !== 1'b1) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    pend      = 1'b1;
                    pend_addr = hs_addr;
                    cnt       = lat;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        rv_auto = 1'b1;
                        rd_auto = pend_addr | 32'h13;
                        pend    = 1'b0;
                    end else begin
                        cnt = cnt - 1;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic        last_v;
        logic [95:0] last_t;
        logic [95:0] cur;
        logic [95:0] exp;
        last_v = 1'b0;
        last_t = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                last_v = 1'b0;
            end else begin
                cur = {InstrD, PCD, PCPlus4D};
                if (ValidD === 1'b1 && (!last_v || cur !== last_t)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL ifid_unexpected act instr=%h pc=%h pc4=%h exp none",
                                 InstrD, PCD, PCPlus4D);
                    end else begin
                        exp = exp_q.pop_front();
                        if (cur !== exp) begin
                            errors++;
                            $display("FAIL ifid act instr=%h pc=%h pc4=%h exp instr=%h pc=%h pc4=%h",
                                     cur[95:64], cur[63:32], cur[31:0],
                                     exp[95:64], exp[63:32], exp[31:0]);
                        end
                    end
                end
                last_v = (ValidD === 1'b1);
                last_t = cur;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
        exp_q.push_back({instr, pc, pc4});
    endtask

    task automatic redirect(input logic [31:0] tgt);
        PCSrcE    = 1'b1;
        PCTargetE = tgt;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ValidD"},    {31'h0, ValidD},   32'h0);
        chk({tag, "_InstrD"},    InstrD,            32'h0);
        chk({tag, "_PCD"},       PCD,               32'h0);
        chk({tag, "_PCPlus4D"},  PCPlus4D,          32'h0);
        chk({tag, "_imem_req"},  {31'h0, imem_req}, 32'h0);
        chk({tag, "_imem_addr"}, imem_addr,         32'h0);
        chk({tag, "_state"},     {30'h0, fsm_state}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem_gnt = 1'b1; lat = 1; stray_rv = 1'b0;

        // Reset takes effect before any clock edge.
        #3 rst = 1'b0;
        #1 chk_reset_outputs("reset_async");
        step(); step();

        // c0: leave reset; one IDLE cycle, then straight-line fetch.
        rst = 1'b1;
        push(32'h13, 32'h0, 32'h4);
        push(32'h17, 32'h4, 32'h8);
        push(32'h1B, 32'h8, 32'hC);
        @(negedge clk); chk("idle_req", {31'h0, imem_req}, 32'h0);
        step();                                                  // c1
        @(negedge clk); chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        step(); step(); step();                                  // c4
        @(negedge clk); chk("hold2_pcd", PCD, 32'h0);
        chk("hold2_valid", {31'h0, ValidD}, 32'h1);
        step(); step(); step();                                  // c7: fetch 0xC, slow reply
        lat = 3;
        push(32'h113, 32'h100, 32'h104);
        step();                                                  // c8: redirect in WAIT
        redirect(32'h100); lat = 1;
        step();                                                  // c9
        PCSrcE = 1'b0;
        @(negedge clk); chk("rdw_valid", {31'h0, ValidD}, 32'h0);
        chk("rdw_req", {31'h0, imem_req}, 32'h0);
        step();                                                  // c10: stale reply
        @(negedge clk); chk("rdw_discard_valid", {31'h0, ValidD}, 32'h0);
        step();                                                  // c11
        @(negedge clk); chk("rdw_addr", imem_addr, 32'h100);
        chk("rdw_req2", {31'h0, imem_req}, 32'h1);
        step(); step();                                          // c13: redirect + grant
        redirect(32'h200);
        push(32'h213, 32'h200, 32'h204);
        step();                                                  // c14
        PCSrcE = 1'b0;
        @(negedge clk); chk("rdg_valid", {31'h0, ValidD}, 32'h0);
        step();                                                  // c15
        @(negedge clk); chk("rdg_addr", imem_addr, 32'h200);
        step(); step(); step();                                  // c18: redirect + rvalid
        redirect(32'h300);
        push(32'h313, 32'h300, 32'h304);
        step();                                                  // c19
        PCSrcE = 1'b0;
        @(negedge clk); chk("rdr_valid", {31'h0, ValidD}, 32'h0);
        chk("rdr_req", {31'h0, imem_req}, 32'h1);
        chk("rdr_addr", imem_addr, 32'h300);
        step(); step();                                          // c21
        StallD = 1'b1;
        step(); step();                                          // c23: HOLD, redirect under stall
        redirect(32'h400);
        push(32'h413, 32'h400, 32'h404);
        @(negedge clk); chk("hold_req", {31'h0, imem_req}, 32'h0);
        chk("hold_pcd", PCD, 32'h300);
        chk("hold_state", {30'h0, fsm_state}, 32'h3);
        step();                                                  // c24
        PCSrcE = 1'b0; StallD = 1'b0;
        @(negedge clk); chk("rdh_valid", {31'h0, ValidD}, 32'h0);
        chk("rdh_addr", imem_addr, 32'h400);
        chk("rdh_req", {31'h0, imem_req}, 32'h1);
        step(); step();                                          // c26: redirect to wrap point
        redirect(32'hFFFFFFFE);
        push(32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0);
        push(32'h13, 32'h0, 32'h4);
        step();                                                  // c27
        PCSrcE = 1'b0;
        step();                                                  // c28
        @(negedge clk); chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
        step(); step();                                          // c30
        @(negedge clk); chk("wrap_pc4", PCPlus4D, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_next_req", {31'h0, imem_req}, 32'h1);
        step(); step();                                          // c32: fetch 0x4, slow reply
        lat = 3;
        step();                                                  // c33: reset while in WAIT
        rst = 1'b0; lat = 1;
        #1 chk_reset_outputs("reset_mid");
        step(); step();                                          // c35: release, stray rvalid
        rst = 1'b1; stray_rv = 1'b1;
        push(32'h13, 32'h0, 32'h4);
        push(32'h17, 32'h4, 32'h8);
        push(32'h1B, 32'h8, 32'hC);
        @(negedge clk); chk("stray_idle_req", {31'h0, imem_req}, 32'h0);
        step();                                                  // c36
        stray_rv = 1'b0;
        @(negedge clk); chk("restart_req", {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        chk("stray_valid", {31'h0, ValidD}, 32'h0);
        step(); step();                                          // c38: stall across fetch of 0x4
        StallD = 1'b1;
        step(); step();                                          // c40
        @(negedge clk); chk("skid_req", {31'h0, imem_req}, 32'h0);
        chk("skid_pcd", PCD, 32'h0);
        step();                                                  // c41
        StallD = 1'b0;
        @(negedge clk); chk("skid_req2", {31'h0, imem_req}, 32'h0);
        step();                                                  // c42
        @(negedge clk); chk("unstall_pcd", PCD, 32'h4);
        chk("unstall_req", {31'h0, imem_req}, 32'h1);
        chk("unstall_addr", imem_addr, 32'h8);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d_pending exp=0_pending", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencing controller for the fetch stage of the 5-stage RISC-V pipeline when instruction memory is a multi-cycle request/grant/response port rather than a combinational ROM. It owns the program counter, issues one instruction fetch at a time, and applies execute-stage redirects (`PCSrcE`/`PCTargetE`) and decode-stage stalls. Stale responses are discarded. It drives the IF/ID pipeline register (`InstrD`, `PCD`, `PCPlus4D`, `ValidD`) consumed by the decode stage.

## Interface
Parameters:
- `RESET_PC`, 32'h00000000, first fetch address after reset.

Ports:
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `StallD`  in  1  decode stage cannot accept; hold IF/ID register.
- `PCSrcE`  in  1  taken branch/jump from execute; single-cycle pulse.
- `PCTargetE`  in  32  redirect target, valid when `PCSrcE`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (word aligned).
- `imem_gnt`  in  1  request accepted this cycle (`imem_req & imem_gnt` = handshake).
- `imem_rvalid`  in  1  response data valid; exactly one per accepted request, earliest the cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `InstrD`  out  32  IF/ID instruction.
- `PCD`  out  32  IF/ID PC.
- `PCPlus4D`  out  32  IF/ID PC+4.
- `ValidD`  out  1  IF/ID holds a real instruction.

## Operation
- Internal state: `pc` (32), `kill` flag, one-entry skid buffer (instr, pc, valid), FSM.
- FSM states:
  - IDLE: entered from reset; `imem_req`=0; always goes to REQ next cycle. `imem_rvalid` is ignored in IDLE.
  - REQ: `imem_req`=1, `imem_addr`=`pc`. On grant, go to WAIT.
  - WAIT: request outstanding; `imem_req`=0. On `imem_rvalid`:
    - if `kill`=1: discard data, clear `kill`, go to REQ.
    - else if IF/ID can load (`StallD`=0, or `ValidD`=0): load IF/ID with {`imem_rdata`, `pc`, `pc`+4}, set `ValidD`, advance `pc` by 4, go to REQ.
    - else: write the skid buffer, advance `pc` by 4, go to HOLD.
  - HOLD: `imem_req`=0. When `StallD` falls, move the buffer into IF/ID, clear the buffer, go to REQ.
- Stall with no buffered data: IF/ID holds its value. The FSM may still issue and await a fetch.
- Redirect (`PCSrcE`=1) has priority over everything except reset:
  - `pc` <= `PCTargetE`.
  - IF/ID cleared: `InstrD`/`PCD`/`PCPlus4D`=0, `ValidD`=0. This applies even under `StallD`.
  - Skid buffer invalidated.
  - From REQ without grant: stay in REQ; `imem_addr` switches to the target next cycle.
  - From REQ with grant in the same cycle: grant consumed for the old address; go to WAIT with `kill`=1.
  - In WAIT without `imem_rvalid`: set `kill`, stay in WAIT.
  - In WAIT with `imem_rvalid` in the same cycle: discard data, go to REQ at target.
  - From HOLD: go to REQ.
- Address arithmetic: 32-bit modulo. 32'hFFFFFFFC + 4 = 32'h00000000, with no flag. `PCTargetE[1:0]` is forced to 0.

## Timing
- Reset (`rst`=0, asynchronous):
  - `pc`=`RESET_PC`, FSM=IDLE, `kill`=0, buffer empty.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `InstrD`=`PCD`=`PCPlus4D`=0, `ValidD`=0.
- First `imem_req` is asserted in the second cycle after reset deassertion (one IDLE cycle).
- Latency: `imem_rvalid` in cycle N gives IF/ID valid in cycle N+1 (registered). The next request is asserted in cycle N+1.
- Zero-wait memory (grant same cycle, rvalid next cycle): one instruction per 2 cycles.
- `imem_req`/`imem_addr` are held stable until grant, except on redirect.
- Reset mid-transaction abandons the outstanding request. Memory must drop it; any `rvalid` arriving in IDLE is ignored.
- At most one request is outstanding; `imem_req`=0 whenever in WAIT or HOLD.

## Test plan
- **Reset then straight-line fetch.** Stimulus: `RESET_PC`=0, memory grants immediately and returns rvalid 1 cycle later with data=addr|0x13. Required: IF/ID shows (0x13,0,4), then (0x17,4,8), then (0x1B,8,0xC), each instruction valid for 2 cycles.
- **Stall with buffering.** Stimulus: `StallD`=1 while the fetch of 0x4 returns. Required: IF/ID holds PC 0x0; `imem_req`=0 during HOLD; on `StallD` falling, IF/ID=PC 0x4 the next cycle and a fetch of 0x8 is requested.
- **Redirect while waiting.** Stimulus: request for 0x8 granted; `PCSrcE`=1 with `PCTargetE`=0x100 before rvalid. Required: the 0x8 response is discarded; `ValidD`=0; next `imem_addr`=0x100; IF/ID later shows `PCD`=0x100, `PCPlus4D`=0x104.
- **Simultaneous events.** Stimulus: (a) redirect and grant in the same cycle; (b) redirect and rvalid in the same cycle; (c) redirect while `StallD`=1 in HOLD. Required: in all three cases no old-path instruction ever reaches IF/ID with `ValidD`=1, and the target is fetched next.
- **Wrap-around.** Stimulus: redirect to 0xFFFFFFFC. Required: `PCPlus4D`=0x00000000 and the next fetch address is 0x00000000.
- **Reset mid-operation.** Stimulus: assert `rst` while in WAIT, then inject a stray rvalid during IDLE. Required: all outputs reach reset values asynchronously; the stray data is ignored; fetch restarts at `RESET_PC`.
